// File: rtl/debounce_multi_if.sv
// debounce_multi_if
//   Groups the front-panel side of the multi-channel debouncer.
//   Parameter N_CH sets the channel count and must match the debouncer.
//   Signals:
//     enable      1     common run enable (0: counters cleared, level held)
//     button      N_CH  raw asynchronous inputs
//     level       N_CH  debounced state (1 = pressed/active)
//     rise_pulse  N_CH  1-cycle pulse on level 0->1
//     fall_pulse  N_CH  1-cycle pulse on level 1->0
//     long_pulse  N_CH  1-cycle pulse after level held 1 for LONG_CYCLES
//     any_event   1     registered OR of all pulses
//   Modports: master drives enable/button; slave is the debouncer.
interface debounce_multi_if #(
  parameter int N_CH = 4
) ();
  logic            enable;
  logic [N_CH-1:0] button;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] rise_pulse;
  logic [N_CH-1:0] fall_pulse;
  logic [N_CH-1:0] long_pulse;
  logic            any_event;

  modport master (
    output enable, button,
    input  level, rise_pulse, fall_pulse, long_pulse, any_event
  );

  modport slave (
    input  enable, button,
    output level, rise_pulse, fall_pulse, long_pulse, any_event
  );
endinterface

// File: rtl/debounce_multi.sv
// debounce_multi
//   N-channel debouncer for buttons/switches in the clk domain. Each channel
//   has a 2-flop synchroniser, a mismatch counter that must reach DB_CYCLES
//   before the debounced level follows the input, rise/fall event pulses and
//   an optional long-press detector (LONG_CYCLES=0 removes it).
//   Ports:
//     clk    in   system clock, rising edge
//     reset  in   asynchronous, active-low reset
//     dbif   slave modport of debounce_multi_if (enable, button in;
//            level, rise/fall/long pulses, any_event out)
module debounce_multi #(
  parameter int N_CH        = 4,
  parameter int DB_CYCLES   = 256,
  parameter int LONG_CYCLES = 0,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic           clk,
  input  logic           reset,
  debounce_multi_if.slave dbif
);

  localparam int              CNT_W    = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  // Raw pin value when nothing is pressed; also the xor mask that turns a
  // raw pin into a logical "pressed" bit.
  localparam logic [N_CH-1:0]  RAW_IDLE = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [N_CH-1:0]  sync1, sync2;
  logic [N_CH-1:0]  s;
  logic [N_CH-1:0]  level_q, rise_q, fall_q, long_q;
  logic             any_q;
  logic [CNT_W-1:0] cnt [N_CH];

  // Sync flops hold raw pin values so reset can preload the idle pin level
  // and no spurious edge appears on reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= RAW_IDLE;
      sync2 <= RAW_IDLE;
    end else begin
      sync1 <= dbif.button;
      sync2 <= sync1;
    end
  end

  assign s = sync2 ^ RAW_IDLE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      rise_q <= '0;
      fall_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        if (!dbif.enable || (s[i] == level_q[i])) begin
          // any agreement (or disable) throws away accumulated progress
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i]     <= '0;
          level_q[i] <= s[i];
          rise_q[i]  <= s[i];
          fall_q[i]  <= ~s[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  generate
    if (LONG_CYCLES > 0) begin : g_long
      localparam int               HOLD_W   = $clog2(LONG_CYCLES + 1);
      localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);
      logic [HOLD_W-1:0] hold [N_CH];

      // hold saturates at HOLD_MAX, so the pulse fires once per press
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < N_CH; i++) hold[i] <= '0;
          long_q <= '0;
        end else begin
          long_q <= '0;
          for (int i = 0; i < N_CH; i++) begin
            if (!dbif.enable || !level_q[i]) begin
              hold[i] <= '0;
            end else if (hold[i] != HOLD_MAX) begin
              hold[i]   <= hold[i] + 1'b1;
              long_q[i] <= (hold[i] == HOLD_MAX - 1'b1);
            end
          end
        end
      end
    end else begin : g_no_long
      assign long_q = '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      any_q <= 1'b0;
    end else begin
      any_q <= |(rise_q | fall_q | long_q);
    end
  end

  assign dbif.level      = level_q;
  assign dbif.rise_pulse = rise_q;
  assign dbif.fall_pulse = fall_q;
  assign dbif.long_pulse = long_q;
  assign dbif.any_event  = any_q;

endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi
//   Directed bench for debounce_multi. dut_a: active-high pins, DB_CYCLES=8,
//   LONG_CYCLES=50. dut_b: active-low pins, DB_CYCLES=8, no long-press.
//   Expected output snapshots {level, rise, fall, long, any} are queued when
//   stimulus is applied and popped when the corresponding edge is reached.
module tb_debounce_multi;

  logic clk;
  logic reset;

  debounce_multi_if #(.N_CH(4)) dif_a ();
  debounce_multi_if #(.N_CH(4)) dif_b ();

  debounce_multi #(.N_CH(4), .DB_CYCLES(8), .LONG_CYCLES(50), .ACTIVE_LOW(0)) dut_a (
    .clk   (clk),
    .reset (reset),
    .dbif  (dif_a)
  );

  debounce_multi #(.N_CH(4), .DB_CYCLES(8), .LONG_CYCLES(0), .ACTIVE_LOW(1)) dut_b (
    .clk   (clk),
    .reset (reset),
    .dbif  (dif_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [16:0] val;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   rise_cnt [4];
  int   fall_cnt [4];
  int   long_cnt [4];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_a(input string tag, input logic [3:0] lv, input logic [3:0] ri,
                          input logic [3:0] fa, input logic [3:0] lo, input logic an);
    exp_t e;
    e.tag = tag;
    e.val = {lv, ri, fa, lo, an};
    sb_a.push_back(e);
  endtask

  task automatic expect_b(input string tag, input logic [3:0] lv, input logic [3:0] ri,
                          input logic [3:0] fa, input logic [3:0] lo, input logic an);
    exp_t e;
    e.tag = tag;
    e.val = {lv, ri, fa, lo, an};
    sb_b.push_back(e);
  endtask

  task automatic check_a();
    exp_t        e;
    logic [16:0] obs;
    obs = {dif_a.level, dif_a.rise_pulse, dif_a.fall_pulse, dif_a.long_pulse, dif_a.any_event};
    n_cmp++;
    if (sb_a.size() == 0) begin
      n_err++;
      $error("FAIL sb_a_empty: observed %h required a queued expectation", obs);
    end else begin
      e = sb_a.pop_front();
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h (lvl,rise,fall,long,any)", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic check_b();
    exp_t        e;
    logic [16:0] obs;
    obs = {dif_b.level, dif_b.rise_pulse, dif_b.fall_pulse, dif_b.long_pulse, dif_b.any_event};
    n_cmp++;
    if (sb_b.size() == 0) begin
      n_err++;
      $error("FAIL sb_b_empty: observed %h required a queued expectation", obs);
    end else begin
      e = sb_b.pop_front();
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h (lvl,rise,fall,long,any)", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cmp_int(input string tag, input int obs, input int expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 4; i++) begin
      rise_cnt[i] = 0;
      fall_cnt[i] = 0;
      long_cnt[i] = 0;
    end
  endtask

  task automatic count_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      tick(1);
      for (int i = 0; i < 4; i++) begin
        rise_cnt[i] += int'(dif_a.rise_pulse[i]);
        fall_cnt[i] += int'(dif_a.fall_pulse[i]);
        long_cnt[i] += int'(dif_a.long_pulse[i]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b0;
    dif_a.enable = 1'b1;
    dif_b.enable = 1'b1;
    dif_a.button = 4'h0;
    dif_b.button = 4'hF;
    clear_counts();

    // reset and release: idle pins must not produce events
    repeat (3) @(negedge clk);
    expect_a("rst_a", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0); check_a();
    expect_b("rst_b", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0); check_b();
    reset = 1'b1;
    expect_a("rel_a", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    expect_b("rel_b", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    tick(12); check_a(); check_b();

    // T1 step on channel 0, then long-press on the same hold
    dif_a.button = 4'b0001;
    expect_a("t1_e9",  4'h0, 4'h0, 4'h0, 4'h0, 1'b0); tick(9); check_a();
    expect_a("t1_e10", 4'h1, 4'h1, 4'h0, 4'h0, 1'b0); tick(1); check_a();
    expect_a("t1_e11", 4'h1, 4'h0, 4'h0, 4'h0, 1'b1); tick(1); check_a();
    expect_a("t1_e12", 4'h1, 4'h0, 4'h0, 4'h0, 1'b0); tick(1); check_a();
    expect_a("t4_l49", 4'h1, 4'h0, 4'h0, 4'h0, 1'b0); tick(47); check_a();
    expect_a("t4_l50", 4'h1, 4'h0, 4'h0, 4'h1, 1'b0); tick(1); check_a();
    expect_a("t4_l51", 4'h1, 4'h0, 4'h0, 4'h0, 1'b1); tick(1); check_a();
    clear_counts();
    count_cycles(100);
    cmp_int("t4_no_repeat", long_cnt[0], 0);
    dif_a.button = 4'b0000;
    expect_a("t1_rel9",  4'h1, 4'h0, 4'h0, 4'h0, 1'b0); tick(9); check_a();
    expect_a("t1_rel10", 4'h0, 4'h0, 4'h1, 4'h0, 1'b0); tick(1); check_a();
    expect_a("t1_rel11", 4'h0, 4'h0, 4'h0, 4'h0, 1'b1); tick(1); check_a();

    // T2 glitch of 7 cycles rejected, 8 cycles accepted
    dif_a.button = 4'b0010;
    tick(7);
    dif_a.button = 4'b0000;
    clear_counts();
    count_cycles(20);
    cmp_int("t2_glitch_rise", rise_cnt[1], 0);
    expect_a("t2_glitch_lvl", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0); check_a();
    dif_a.button = 4'b0010;
    tick(8);
    dif_a.button = 4'b0000;
    expect_a("t2_8cyc_rise", 4'h2, 4'h2, 4'h0, 4'h0, 1'b0); tick(2); check_a();
    expect_a("t2_8cyc_fall", 4'h0, 4'h0, 4'h2, 4'h0, 1'b0); tick(8); check_a();
    tick(2);

    // simultaneous events on channels 1 and 2
    dif_a.button = 4'b0110;
    expect_a("sim_rise", 4'h6, 4'h6, 4'h0, 4'h0, 1'b0); tick(10); check_a();
    dif_a.button = 4'b0000;
    expect_a("sim_any",  4'h6, 4'h0, 4'h0, 4'h0, 1'b1); tick(1); check_a();
    expect_a("sim_fall", 4'h0, 4'h0, 4'h6, 4'h0, 1'b0); tick(9); check_a();
    tick(2);

    // T4 release at hold=30 gives no long pulse
    dif_a.button = 4'b1000;
    expect_a("t4s_rise", 4'h8, 4'h8, 4'h0, 4'h0, 1'b0); tick(10); check_a();
    expect_a("t4s_h30",  4'h8, 4'h0, 4'h0, 4'h0, 1'b0); tick(30); check_a();
    dif_a.button = 4'b0000;
    clear_counts();
    count_cycles(12);
    cmp_int("t4s_long", long_cnt[3], 0);
    cmp_int("t4s_fall", fall_cnt[3], 1);
    expect_a("t4s_end", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0); check_a();

    // T3 active-low channel 2 on dut_b
    dif_b.button = 4'b1011;
    expect_b("t3_e9",   4'h0, 4'h0, 4'h0, 4'h0, 1'b0); tick(9); check_b();
    expect_b("t3_e10",  4'h4, 4'h4, 4'h0, 4'h0, 1'b0); tick(1); check_b();
    expect_b("t3_e11",  4'h4, 4'h0, 4'h0, 4'h0, 1'b1); tick(1); check_b();
    tick(9);
    dif_b.button = 4'hF;
    expect_b("t3_rel9",  4'h4, 4'h0, 4'h0, 4'h0, 1'b0); tick(9); check_b();
    expect_b("t3_rel10", 4'h0, 4'h0, 4'h4, 4'h0, 1'b0); tick(1); check_b();
    expect_b("t3_rel11", 4'h0, 4'h0, 4'h0, 4'h0, 1'b1); tick(1); check_b();

    // T5 reset with cnt[0]=5 discards progress
    dif_a.button = 4'b0001;
    tick(7);
    reset = 1'b0;
    #1;
    expect_a("t5_rst_a", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0); check_a();
    expect_b("t5_rst_b", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0); check_b();
    expect_a("t5_rst_hold", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0); tick(1); check_a();
    reset = 1'b1;
    expect_a("t5_e9",  4'h0, 4'h0, 4'h0, 4'h0, 1'b0); tick(9); check_a();
    expect_a("t5_e10", 4'h1, 4'h1, 4'h0, 4'h0, 1'b0); tick(1); check_a();

    // T6 enable low mid-count, full count after enable returns
    dif_a.button = 4'b0000;
    expect_a("t6_mid",   4'h1, 4'h0, 4'h0, 4'h0, 1'b0); tick(5); check_a();
    dif_a.enable = 1'b0;
    expect_a("t6_dis",   4'h1, 4'h0, 4'h0, 4'h0, 1'b0); tick(10); check_a();
    dif_a.enable = 1'b1;
    expect_a("t6_en7",   4'h1, 4'h0, 4'h0, 4'h0, 1'b0); tick(7); check_a();
    expect_a("t6_en8",   4'h0, 4'h0, 4'h1, 4'h0, 1'b0); tick(1); check_a();
    expect_b("b_idle",   4'h0, 4'h0, 4'h0, 4'h0, 1'b0); check_b();

    cmp_int("sb_a_drained", sb_a.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
